// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared types and constants for the register-file write-back arbiter.
// Priority state encoding, default widths and the hardwired-zero register index.
package regfile_wb_arbiter_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int ADDR_W_DEF = 4;

  // Register index 0 reads as zero, so writes to it are dropped.
  localparam int ZERO_REG = 0;

  typedef logic [0:0] pri_state_t;

  localparam pri_state_t PRI_A = 1'b0;
  localparam pri_state_t PRI_B = 1'b1;

  function automatic pri_state_t pri_other(input pri_state_t state);
    return (state == PRI_A) ? PRI_B : PRI_A;
  endfunction

endpackage

// File: rtl/regfile_wb_arbiter_wb_rr_pick.sv
// Round-robin pick between the two write-back requesters.
// Purely combinational: readies and next priority from the valids and current priority.
module wb_rr_pick
  import regfile_wb_arbiter_pkg::*;
(
  input  logic       i_a_valid,
  input  logic       i_b_valid,
  input  pri_state_t i_state,
  output logic       o_a_ready,
  output logic       o_b_ready,
  output pri_state_t o_state_next
);

  always_comb begin
    o_a_ready    = 1'b0;
    o_b_ready    = 1'b0;
    o_state_next = i_state;
    if (i_a_valid && i_b_valid) begin
      // Contention: holder wins and priority passes to the loser.
      o_a_ready    = (i_state == PRI_A);
      o_b_ready    = (i_state == PRI_B);
      o_state_next = pri_other(i_state);
    end else if (i_a_valid) begin
      o_a_ready = 1'b1;
    end else if (i_b_valid) begin
      o_b_ready = 1'b1;
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter for the register file's single write port (A = ALU, B = load).
// Define WB_BYPASS_EN to forward the pending write onto the two read ports.
//
// Handshake: a request transfers in the cycle x_valid && x_ready are both high;
// x_ready never rises without x_valid, and the requester holds its request until then.
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_valid,
  input  logic [ADDR_W-1:0] a_reg,
  input  logic [DATA_W-1:0] a_data,
  output logic              a_ready,
  input  logic              b_valid,
  input  logic [ADDR_W-1:0] b_reg,
  input  logic [DATA_W-1:0] b_data,
  output logic              b_ready,
  output logic              WriteEnable,
  output logic [ADDR_W-1:0] WriteReg,
  output logic [DATA_W-1:0] WriteData,
  input  logic [ADDR_W-1:0] SrcReg1,
  input  logic [ADDR_W-1:0] SrcReg2,
  input  logic [DATA_W-1:0] RFData1,
  input  logic [DATA_W-1:0] RFData2,
  output logic [DATA_W-1:0] SrcData1,
  output logic [DATA_W-1:0] SrcData2,
  output pri_state_t        o_dbg_state
);

  pri_state_t        r_pri;
  pri_state_t        w_pri_next;
  logic              w_a_ready;
  logic              w_b_ready;
  logic              w_accept;
  logic [ADDR_W-1:0] w_sel_reg;
  logic [DATA_W-1:0] w_sel_data;
  logic              r_we;
  logic [ADDR_W-1:0] r_wreg;
  logic [DATA_W-1:0] r_wdata;

  wb_rr_pick u_pick (
    .i_a_valid    (a_valid),
    .i_b_valid    (b_valid),
    .i_state      (r_pri),
    .o_a_ready    (w_a_ready),
    .o_b_ready    (w_b_ready),
    .o_state_next (w_pri_next)
  );

  assign w_accept   = w_a_ready | w_b_ready;
  assign w_sel_reg  = w_a_ready ? a_reg : b_reg;
  assign w_sel_data = w_a_ready ? a_data : b_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pri   <= PRI_A;
      r_we    <= 1'b0;
      r_wreg  <= '0;
      r_wdata <= '0;
    end else begin
      r_pri <= w_pri_next;
      if (w_accept) begin
        // R0 writes still load reg/data but never raise the strobe.
        r_we    <= (w_sel_reg != ADDR_W'(ZERO_REG));
        r_wreg  <= w_sel_reg;
        r_wdata <= w_sel_data;
      end else begin
        r_we <= 1'b0;
      end
    end
  end

  assign a_ready     = w_a_ready;
  assign b_ready     = w_b_ready;
  assign WriteEnable = r_we;
  assign WriteReg    = r_wreg;
  assign WriteData   = r_wdata;
  assign o_dbg_state = r_pri;

`ifdef WB_BYPASS_EN
  assign SrcData1 = (r_we && (SrcReg1 == r_wreg)) ? r_wdata : RFData1;
  assign SrcData2 = (r_we && (SrcReg2 == r_wreg)) ? r_wdata : RFData2;
`else
  logic w_unused_src;
  assign w_unused_src = ^{SrcReg1, SrcReg2};
  assign SrcData1     = RFData1;
  assign SrcData2     = RFData2;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter; expectations follow WB_BYPASS_EN when defined.
// Inputs change on the falling edge; outputs are checked between edges.
module tb_regfile_wb_arbiter;
  import regfile_wb_arbiter_pkg::*;

  localparam int DW = 16;
  localparam int AW = 4;

  logic          clk;
  logic          rst;
  logic          a_valid;
  logic [AW-1:0] a_reg;
  logic [DW-1:0] a_data;
  logic          a_ready;
  logic          b_valid;
  logic [AW-1:0] b_reg;
  logic [DW-1:0] b_data;
  logic          b_ready;
  logic          we;
  logic [AW-1:0] wreg;
  logic [DW-1:0] wdata;
  logic [AW-1:0] src_reg1;
  logic [AW-1:0] src_reg2;
  logic [DW-1:0] rf_data1;
  logic [DW-1:0] rf_data2;
  logic [DW-1:0] src_data1;
  logic [DW-1:0] src_data2;
  pri_state_t    dbg_state;

  int n_cmp;
  int n_err;
  logic [AW-1:0] exp_q[$];
  logic [AW-1:0] exp_reg;

  regfile_wb_arbiter #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk         (clk),
    .rst         (rst),
    .a_valid     (a_valid),
    .a_reg       (a_reg),
    .a_data      (a_data),
    .a_ready     (a_ready),
    .b_valid     (b_valid),
    .b_reg       (b_reg),
    .b_data      (b_data),
    .b_ready     (b_ready),
    .WriteEnable (we),
    .WriteReg    (wreg),
    .WriteData   (wdata),
    .SrcReg1     (src_reg1),
    .SrcReg2     (src_reg2),
    .RFData1     (rf_data1),
    .RFData2     (rf_data2),
    .SrcData1    (src_data1),
    .SrcData2    (src_data2),
    .o_dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic drive_a(input logic v, input logic [AW-1:0] r, input logic [DW-1:0] d);
    a_valid = v;
    a_reg   = r;
    a_data  = d;
  endtask

  task automatic drive_b(input logic v, input logic [AW-1:0] r, input logic [DW-1:0] d);
    b_valid = v;
    b_reg   = r;
    b_data  = d;
  endtask

  initial begin
    n_cmp    = 0;
    n_err    = 0;
    rst      = 1'b1;
    src_reg1 = '0;
    src_reg2 = '0;
    rf_data1 = 16'h7777;
    rf_data2 = 16'h8888;
    drive_a(1'b1, 4'd9, 16'h1111);
    drive_b(1'b1, 4'd10, 16'h2222);

    // reset for two cycles, both valid
    repeat (2) @(negedge clk);
    #1;
    check_val("rst_we", 32'(we), 32'd0);
    check_val("rst_wreg", 32'(wreg), 32'd0);
    check_val("rst_wdata", 32'(wdata), 32'd0);
    check_val("rst_a_ready", 32'(a_ready), 32'd1);
    check_val("rst_b_ready", 32'(b_ready), 32'd0);
    check_val("rst_state", 32'(dbg_state), 32'(PRI_A));
    check_val("rst_src1", 32'(src_data1), 32'h7777);
    check_val("rst_src2", 32'(src_data2), 32'h8888);

    @(negedge clk);
    rst = 1'b0;
    drive_a(1'b0, '0, '0);
    drive_b(1'b0, '0, '0);

    // single requester A
    @(negedge clk);
    drive_a(1'b1, 4'd3, 16'hBEEF);
    #1;
    check_val("single_a_ready", 32'(a_ready), 32'd1);
    check_val("single_b_ready", 32'(b_ready), 32'd0);
    @(negedge clk);
    drive_a(1'b0, '0, '0);
    #1;
    check_val("single_we", 32'(we), 32'd1);
    check_val("single_wreg", 32'(wreg), 32'd3);
    check_val("single_wdata", 32'(wdata), 32'hBEEF);
    check_val("single_state", 32'(dbg_state), 32'(PRI_A));
    @(negedge clk);
    #1;
    check_val("single_we_drop", 32'(we), 32'd0);
    check_val("single_wreg_hold", 32'(wreg), 32'd3);
    check_val("single_wdata_hold", 32'(wdata), 32'hBEEF);

    // contention: grants A,B,A,B; WriteReg 1,2,1,2
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        exp_reg = exp_q.pop_front();
        check_val("cont_we", 32'(we), 32'd1);
        check_val("cont_wreg", 32'(wreg), 32'(exp_reg));
        check_val("cont_wdata", 32'(wdata), (exp_reg == 4'd1) ? 32'h0001 : 32'h0002);
      end
      drive_a(1'b1, 4'd1, 16'h0001);
      drive_b(1'b1, 4'd2, 16'h0002);
      #1;
      check_val("cont_a_ready", 32'(a_ready), (i % 2 == 0) ? 32'd1 : 32'd0);
      check_val("cont_b_ready", 32'(b_ready), (i % 2 == 1) ? 32'd1 : 32'd0);
      exp_q.push_back((i % 2 == 0) ? 4'd1 : 4'd2);
    end
    @(negedge clk);
    drive_a(1'b0, '0, '0);
    drive_b(1'b0, '0, '0);
    while (exp_q.size() > 0) begin
      exp_reg = exp_q.pop_front();
      check_val("cont_last_wreg", 32'(wreg), 32'(exp_reg));
      check_val("cont_last_wdata", 32'(wdata), 32'h0002);
    end
    check_val("cont_end_state", 32'(dbg_state), 32'(PRI_A));

    // R0 write from B: accepted, dropped
    @(negedge clk);
    drive_b(1'b1, 4'd0, 16'hFFFF);
    #1;
    check_val("r0_b_ready", 32'(b_ready), 32'd1);
    check_val("r0_a_ready", 32'(a_ready), 32'd0);
    @(negedge clk);
    drive_b(1'b0, '0, '0);
    #1;
    check_val("r0_we", 32'(we), 32'd0);
    check_val("r0_wreg", 32'(wreg), 32'd0);
    check_val("r0_wdata", 32'(wdata), 32'hFFFF);
    check_val("r0_state", 32'(dbg_state), 32'(PRI_A));
    src_reg1 = 4'd0;
    rf_data1 = 16'h0000;
    #1;
    check_val("r0_no_bypass", 32'(src_data1), 32'h0000);

    // bypass of pending R5 write
    @(negedge clk);
    drive_a(1'b1, 4'd5, 16'h1234);
    @(negedge clk);
    drive_a(1'b0, '0, '0);
    src_reg1 = 4'd5;
    rf_data1 = 16'h0000;
    src_reg2 = 4'd6;
    rf_data2 = 16'h5555;
    #1;
`ifdef WB_BYPASS_EN
    check_val("byp_src1", 32'(src_data1), 32'h1234);
`else
    check_val("byp_src1", 32'(src_data1), 32'h0000);
`endif
    check_val("byp_src2", 32'(src_data2), 32'h5555);
    @(negedge clk);
    #1;
    check_val("byp_src1_after", 32'(src_data1), 32'h0000);

    // reset during a pending write to R7
    @(negedge clk);
    drive_a(1'b1, 4'd7, 16'hABCD);
    #1;
    check_val("mid_a_ready", 32'(a_ready), 32'd1);
    @(negedge clk);
    drive_a(1'b0, '0, '0);
    #1;
    check_val("mid_we_pre", 32'(we), 32'd1);
    check_val("mid_wreg_pre", 32'(wreg), 32'd7);
    rst = 1'b1;
    #1;
    check_val("mid_we_rst", 32'(we), 32'd0);
    check_val("mid_wreg_rst", 32'(wreg), 32'd0);
    check_val("mid_wdata_rst", 32'(wdata), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #1;
    check_val("mid_we_after", 32'(we), 32'd0);

    // final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
